dmem_access_ctrl: RTL
=====================

# dmem_access_ctrl

Data-memory access sequencer for the RV32I core. It sits between the instruction decoder/ALU and a data-memory bus that has wait states. For every load or store it raises `stall` to freeze the PC and register file, runs a req/gnt/rvalid bus handshake, and generates byte enables, lane-aligned write data and sign/zero-extended load data. Misaligned or unsupported accesses are rejected with a one-cycle fault pulse and never reach the bus.

## Interface
Parameters:
- `TIMEOUT`, default 15: bus cycles allowed per access before abort (used only with `DMEM_TIMEOUT_EN`); counter is 8 bits wide.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `mem_read`  in  1  current instruction is a load
- `mem_write`  in  1  current instruction is a store
- `funct3`  in  3  access size/sign, instruction[14:12]
- `addr`  in  32  byte address (ALU result)
- `wdata`  in  32  store data (rs2)
- `stall`  out  1  hold PC and register writes
- `rdata`  out  32  extended load data
- `access_fault`  out  1  one-cycle pulse on rejected or aborted access
- `bus_req`  out  1  bus request
- `bus_we`  out  1  1 = write
- `bus_addr`  out  32  word address (`addr[31:2]`, 2'b00)
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  lane-replicated store data
- `bus_gnt`  in  1  request accepted
- `bus_rvalid`  in  1  read data valid / write acknowledge
- `bus_rdata`  in  32  read word

## Operation
- **States:** IDLE, REQ, WAIT, DONE.
- **Legal accesses:**
  - Loads: funct3 0 (lb), 1 (lh), 2 (lw), 4 (lbu), 5 (lhu).
  - Stores: funct3 0, 1, 2.
  - lh/lhu/sh require `addr[0]`=0. lw/sw require `addr[1:0]`=0.
  - `mem_read` and `mem_write` both high is illegal.
- **IDLE:**
  - Legal access: latch `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, funct3 and `addr[1:0]`, then go to REQ.
  - Illegal access: pulse `access_fault` the next cycle and stay in IDLE. No bus activity, no stall.
  - `bus_rvalid` and `bus_gnt` are ignored in IDLE.
- **REQ:** `bus_req`=1, with all bus outputs stable.
  - `bus_gnt` & `bus_rvalid` → DONE.
  - `bus_gnt` alone → WAIT.
- **WAIT:** `bus_req`=0. `bus_rvalid` → DONE.
- **DONE:** one cycle with `stall`=0 so the core commits; then → IDLE. `mem_read`/`mem_write` are ignored in DONE.
- **Load capture:** on the `bus_rvalid` that ends a load, `rdata` gets the lane selected by the latched `addr[1:0]`, extended per funct3. Signed = lb/lh. `rdata` holds until the next load completes.
- **Store lanes:**
  - sb: `bus_be`=4'b0001<<addr[1:0], data byte replicated ×4.
  - sh: `bus_be`=4'b0011<<(2·addr[1]), half replicated ×2.
  - sw: `bus_be`=4'b1111.
  - Loads drive `bus_be`=4'b1111.
- **Stall:** `stall` = (IDLE & legal access) | REQ | WAIT. The IDLE term is combinational from the inputs.

## Timing
- **Reset values:** state IDLE; `stall`=0 (absent legal access), `rdata`=0, `access_fault`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0.
- **Reset mid-access:** asserting `rst_n` low mid-access drops `bus_req` immediately and returns to IDLE. A late `bus_rvalid` is ignored.
- **Registered outputs:** `bus_*`, `rdata` and `access_fault` are registered. `stall` is not.
- **Minimum latency:** load/store occupies 3 cycles (IDLE, REQ with gnt+rvalid, DONE). Each extra gnt or rvalid wait cycle adds one.
- **`bus_req` rules:** never deasserts in REQ before `bus_gnt`. At most one outstanding access.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on IDLE→REQ and increments in REQ/WAIT.
  - When it reaches `TIMEOUT` without completion: `bus_req` drops, go to DONE, `rdata` is unchanged, and `access_fault` pulses in the DONE cycle.
- Undefined: no counter; REQ/WAIT wait indefinitely. `TIMEOUT` is unused.

## Test plan
- **lw, zero wait states:** `addr`=0x100, `bus_gnt`+`bus_rvalid` in REQ, `bus_rdata`=0xDEADBEEF → `stall` high for 2 cycles, `rdata`=0xDEADBEEF in DONE, `bus_be`=4'hF.
- **lb:** `addr`=0x103, `bus_rdata`=0x80112233 → `rdata`=0xFFFFFF80. **lbu**, same address → `rdata`=0x00000080.
- **sh:** `addr`=0x202, `wdata`=0x0000ABCD → `bus_we`=1, `bus_be`=4'b1100, `bus_wdata`=0xABCDABCD, `bus_addr`=0x200. `bus_gnt` delayed 3 cycles → `bus_req` held for 4 cycles.
- **Misaligned lw:** `addr`=0x102 → `access_fault` single pulse, `stall`=0, `bus_req` never asserted.
- **Reset during WAIT:** then `bus_rvalid` arrives → state IDLE, `rdata`=0, `stall`=0.
- **With `DMEM_TIMEOUT_EN`, `TIMEOUT`=15, `bus_gnt` never asserted:** `bus_req` drops after 15 cycles, `access_fault` pulses, `stall` releases in the DONE cycle.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: data-memory access sequencer for the RV32I core.
//
// For each load or store, this block holds the core with `stall` and runs one
// req/gnt/rvalid transaction on the data bus. It produces the byte enables and
// the lane-replicated store data. Load data is sign- or zero-extended into `rdata`.
// A misaligned or unsupported access gives a one-cycle `access_fault` pulse
// and does not reach the bus.
//
// Optional feature macro: DMEM_TIMEOUT_EN
//   When this macro is defined, an access that is not finished after TIMEOUT
//   bus cycles is aborted. The FSM goes to DONE and pulses `access_fault`.
//   When it is not defined, REQ and WAIT wait forever.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_read, mem_write   load / store request from the decoder
//   funct3, addr, wdata   access size/sign, byte address, store data
//   stall                 hold PC and register file (combinational)
//   rdata                 extended load data (registered, held until next load)
//   access_fault          one-cycle pulse on rejected or aborted access
//   bus_req/we/addr/be/wdata   registered bus request outputs
//   bus_gnt, bus_rvalid, bus_rdata   bus responses

module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    if (TIMEOUT > 255) begin : g_timeout_range
        $error("TIMEOUT must fit the 8-bit timeout counter");
    end

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;

    logic        legal;
    logic        timeout;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rdata_shift;
    logic [31:0] load_data;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    logic [7:0] cnt_q, cnt_d;

    // The abort happens in the cycle that brings the count up to TIMEOUT. This
    // gives exactly TIMEOUT cycles spent in REQ/WAIT.
    assign timeout = (cnt_q + 8'd1 == TimeoutCnt);
`else
    assign timeout = 1'b0;
`endif

    // Legality check: one direction only, a supported funct3, and natural alignment.
    always_comb begin
        legal = 1'b0;
        if (mem_read && !mem_write) begin
            unique case (funct3)
                3'd0, 3'd4: legal = 1'b1;
                3'd1, 3'd5: legal = ~addr[0];
                3'd2:       legal = (addr[1:0] == 2'b00);
                default:    legal = 1'b0;
            endcase
        end else if (mem_write && !mem_read) begin
            unique case (funct3)
                3'd0:    legal = 1'b1;
                3'd1:    legal = ~addr[0];
                3'd2:    legal = (addr[1:0] == 2'b00);
                default: legal = 1'b0;
            endcase
        end
    end

    // Store lane placement. The data is replicated so every enabled lane
    // carries the right bytes whatever the offset.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata;
        if (mem_write) begin
            unique case (funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << addr[1:0];
                    wdata_new = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_new    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{wdata[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = wdata;
                end
            endcase
        end
    end

    // Load extraction. Shift the selected lane down to bit 0, then extend it.
    // Halfword loads are aligned, so lane_q is 0 or 2 for them.
    always_comb begin
        rdata_shift = bus_rdata >> {lane_q, 3'b000};
        unique case (funct3_q)
            3'd0:    load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'd1:    load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'd4:    load_data = {24'd0, rdata_shift[7:0]};
            3'd5:    load_data = {16'd0, rdata_shift[15:0]};
            default: load_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        fault_d     = 1'b0;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        stall       = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (legal) begin
                    stall       = 1'b1;
                    state_d     = StReq;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_new;
                    bus_wdata_d = wdata_new;
                    funct3_d    = funct3;
                    lane_d      = addr[1:0];
`ifdef DMEM_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                end else if (mem_read || mem_write) begin
                    fault_d = 1'b1;
                end
            end

            StReq: begin
                stall = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (bus_gnt && bus_rvalid) begin
                    state_d   = StDone;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        rdata_d = load_data;
                    end
                end else if (timeout) begin
                    state_d   = StDone;
                    bus_req_d = 1'b0;
                    fault_d   = 1'b1;
                end else if (bus_gnt) begin
                    state_d   = StWait;
                    bus_req_d = 1'b0;
                end
            end

            StWait: begin
                stall = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (bus_rvalid) begin
                    state_d = StDone;
                    if (!bus_we_q) begin
                        rdata_d = load_data;
                    end
                end else if (timeout) begin
                    state_d = StDone;
                    fault_d = 1'b1;
                end
            end

            StDone: begin
                // The core commits in this cycle. New requests are seen only back in IDLE.
                state_d = StIdle;
            end

            default: begin
                state_d   = StIdle;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            fault_q     <= 1'b0;
            funct3_q    <= 3'd0;
            lane_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign rdata        = rdata_q;
    assign access_fault = fault_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;

endmodule
